pll_lock_reset_seq: RTL and testbench

- Consumer-side controller for the board rPLL; runs on the free-running 27 MHz input clock.
- Drives the PLL RESET pin and watches the asynchronous PLL LOCK output.
- Holds the system reset until lock has been stable, and re-sequences on lock loss.
- Gives up with a sticky fault after repeated lock timeouts; sits between the PLL wrapper and the top-level reset tree.

---
 rtl/pll_seq_pkg.sv | 12 +
 rtl/sync_2ff.sv | 13 +
 rtl/pll_lock_reset_seq.sv | 112 +++++++++++
 tb/tb_pll_lock_reset_seq.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg: shared state encoding and counter widths for the PLL lock/reset sequencer.
package pll_seq_pkg;
  typedef enum logic [2:0] {
    HOLD      = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } pll_seq_state_e;
  localparam int unsigned LOSS_CNT_W  = 8;
  localparam int unsigned RETRY_CNT_W = 4;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: generic two-flop synchroniser with async active-low reset.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);
  logic [1:0] sync_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[0], d_i};
  assign q_o = sync_q[1];
endmodule

// File: rtl/pll_lock_reset_seq.sv
// pll_lock_reset_seq: PLL reset/lock sequencer gating the system reset.
// Define PLL_LOCK_DEGLITCH_EN to tolerate lock-low runs shorter than GLITCH_CYCLES in RUN.
module pll_lock_reset_seq
  import pll_seq_pkg::*;
#(
  parameter int unsigned RESET_CYCLES  = 32,
  parameter int unsigned LOCK_TIMEOUT  = 270000,
  parameter int unsigned STABLE_CYCLES = 2700,
  parameter int unsigned MAX_RETRIES   = 4,
  parameter int unsigned GLITCH_CYCLES = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   pll_lock_i,
  output logic                   pll_reset_o,
  output logic                   sys_rst_n_o,
  output logic                   ready_o,
  output logic                   fault_o,
  output logic [RETRY_CNT_W-1:0] retry_cnt_o,
  output logic [LOSS_CNT_W-1:0]  loss_cnt_o,
  output logic [2:0]             state_o
);
  localparam int unsigned M1 = RESET_CYCLES > LOCK_TIMEOUT ? RESET_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned M2 = M1 > STABLE_CYCLES ? M1 : STABLE_CYCLES;
  localparam int unsigned TW = M2 > 1 ? $clog2(M2) : 1;
`ifdef PLL_LOCK_DEGLITCH_EN
  localparam bit DEGLITCH = 1'b1;
`else
  localparam bit DEGLITCH = 1'b0;
`endif
  // Without deglitching the threshold collapses to one low cycle.
  localparam int unsigned GLIM = DEGLITCH ? GLITCH_CYCLES : 1;
  localparam int unsigned GW   = $clog2(GLIM + 1);
  pll_seq_state_e         state_q, state_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic [GW-1:0]          glitch_q, glitch_d;
  logic [RETRY_CNT_W-1:0] retry_q, retry_d;
  logic [LOSS_CNT_W-1:0]  loss_q, loss_d;
  logic                   pll_reset_q, pll_reset_d;
  logic                   sys_rst_n_q, sys_rst_n_d;
  logic                   ready_q, ready_d;
  logic                   fault_q, fault_d;
  logic                   lock_s;
  sync_2ff u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (pll_lock_i),
    .q_o   (lock_s)
  );
  always_comb begin
    state_d  = state_q;
    retry_d  = retry_q;
    loss_d   = loss_q;
    glitch_d = '0;
    case (state_q)
      HOLD:      if (timer_q == TW'(RESET_CYCLES - 1)) state_d = WAIT_LOCK;
      WAIT_LOCK: if (lock_s) state_d = STABLE;
                 else if (timer_q == TW'(LOCK_TIMEOUT - 1)) begin
                   retry_d = retry_q + 1'b1;
                   state_d = (retry_d == RETRY_CNT_W'(MAX_RETRIES)) ? FAULT : HOLD;
                 end
      STABLE:    if (!lock_s) state_d = WAIT_LOCK;
                 else if (timer_q == TW'(STABLE_CYCLES - 1)) begin
                   state_d = RUN;
                   retry_d = '0;
                 end
      RUN:       if (!lock_s) begin
                   if (glitch_q == GW'(GLIM - 1)) begin
                     state_d = HOLD;
                     loss_d  = (&loss_q) ? loss_q : loss_q + 1'b1;
                   end else glitch_d = glitch_q + 1'b1;
                 end
      FAULT:     state_d = FAULT;
      default:   state_d = HOLD;
    endcase
    // The timer only runs in the timed states, so it can never wrap.
    timer_d     = (state_d != state_q || state_q == RUN || state_q == FAULT) ? '0 : timer_q + 1'b1;
    pll_reset_d = state_d == HOLD || state_d == FAULT;
    sys_rst_n_d = state_d == RUN;
    ready_d     = state_d == RUN;
    fault_d     = state_d == FAULT;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q     <= HOLD;
      timer_q     <= '0;
      glitch_q    <= '0;
      retry_q     <= '0;
      loss_q      <= '0;
      pll_reset_q <= 1'b1;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      glitch_q    <= glitch_d;
      retry_q     <= retry_d;
      loss_q      <= loss_d;
      pll_reset_q <= pll_reset_d;
      sys_rst_n_q <= sys_rst_n_d;
      ready_q     <= ready_d;
      fault_q     <= fault_d;
    end
  assign pll_reset_o = pll_reset_q;
  assign sys_rst_n_o = sys_rst_n_q;
  assign ready_o     = ready_q;
  assign fault_o     = fault_q;
  assign retry_cnt_o = retry_q;
  assign loss_cnt_o  = loss_q;
  assign state_o     = state_q;
endmodule

// File: tb/tb_pll_lock_reset_seq.sv
// tb_pll_lock_reset_seq: vector table, directed corner sequences and randomized lock
// activity checked against a countdown-based behavioural model.
module tb_pll_lock_reset_seq;
  localparam int RC = 4, LT = 20, SC = 10, MR = 3, GC = 3;
`ifdef PLL_LOCK_DEGLITCH_EN
  localparam bit DG = 1'b1;
`else
  localparam bit DG = 1'b0;
`endif
  logic       clk = 1'b0, rst_n = 1'b0, pll_lock_i = 1'b0;
  logic       pll_reset_o, sys_rst_n_o, ready_o, fault_o;
  logic [3:0] retry_cnt_o;
  logic [7:0] loss_cnt_o;
  logic [2:0] state_o;
  int n_tests = 0, n_fail = 0;
  int m_st, m_left, m_retry, m_loss, m_gl;
  bit sh0, sh1;
  pll_lock_reset_seq #(.RESET_CYCLES(RC), .LOCK_TIMEOUT(LT), .STABLE_CYCLES(SC),
                       .MAX_RETRIES(MR), .GLITCH_CYCLES(GC)) dut (
    .clk(clk), .rst_n(rst_n), .pll_lock_i(pll_lock_i), .pll_reset_o(pll_reset_o),
    .sys_rst_n_o(sys_rst_n_o), .ready_o(ready_o), .fault_o(fault_o),
    .retry_cnt_o(retry_cnt_o), .loss_cnt_o(loss_cnt_o), .state_o(state_o));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic model_reset();
    m_st = 0; m_left = RC; m_retry = 0; m_loss = 0; m_gl = 0; sh0 = 0; sh1 = 0;
  endtask
  // Phases count down the cycles they still have; lock decisions see the 2-cycle-old input.
  task automatic model_edge(input bit lk);
    bit ls;
    ls = sh1;
    case (m_st)
      0: begin m_left--; if (m_left == 0) begin m_st = 1; m_left = LT; end end
      1: if (ls) begin m_st = 2; m_left = SC; end
         else begin
           m_left--;
           if (m_left == 0) begin
             m_retry++;
             if (m_retry == MR) m_st = 4; else begin m_st = 0; m_left = RC; end
           end
         end
      2: if (!ls) begin m_st = 1; m_left = LT; end
         else begin m_left--; if (m_left == 0) begin m_st = 3; m_retry = 0; end end
      3: if (!ls) begin
           m_gl++;
           if (m_gl >= (DG ? GC : 1)) begin
             m_gl = 0; m_st = 0; m_left = RC;
             if (m_loss < 255) m_loss++;
           end
         end else m_gl = 0;
      default: ;
    endcase
    sh1 = sh0; sh0 = lk;
  endtask
  task automatic check_model();
    chk("model state", state_o, m_st);
    chk("model pll_reset", pll_reset_o, m_st == 0 || m_st == 4);
    chk("model sys_rst_n", sys_rst_n_o, m_st == 3);
    chk("model ready", ready_o, m_st == 3);
    chk("model fault", fault_o, m_st == 4);
    chk("model retry", retry_cnt_o, m_retry);
    chk("model loss", loss_cnt_o, m_loss);
  endtask
  task automatic tick(input bit lk);
    pll_lock_i = lk;
    @(posedge clk);
    model_edge(lk);
    #1 check_model();
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; pll_lock_i = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  typedef struct {bit lk; int n; int st; bit sys; int retry; int loss;} vec_t;
  vec_t tbl[6];
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    tbl[0] = '{1'b0, 6, 1, 1'b0, 0, 0};
    tbl[1] = '{1'b1, 13, 3, 1'b1, 0, 0};
    tbl[2] = '{1'b0, 1, 3, 1'b1, 0, 0};
    tbl[3] = '{1'b1, 1, 3, 1'b1, 0, 0};
    tbl[4] = '{1'b1, 1, DG ? 3 : 0, DG, 0, DG ? 0 : 1};
    tbl[5] = '{1'b1, 15, 3, 1'b1, 0, DG ? 0 : 1};
    model_reset();
    #12;
    chk("reset state", state_o, 0);
    chk("reset pll_reset", pll_reset_o, 1);
    chk("reset sys_rst_n", sys_rst_n_o, 0);
    chk("reset fault", fault_o, 0);
    do_reset();
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < tbl[i].n; k++) tick(tbl[i].lk);
      chk($sformatf("vec%0d state", i), state_o, tbl[i].st);
      chk($sformatf("vec%0d sys_rst_n", i), sys_rst_n_o, tbl[i].sys);
      chk($sformatf("vec%0d pll_reset", i), pll_reset_o, tbl[i].st == 0);
      chk($sformatf("vec%0d retry", i), retry_cnt_o, tbl[i].retry);
      chk($sformatf("vec%0d loss", i), loss_cnt_o, tbl[i].loss);
    end
    // Clean bring-up timing
    do_reset();
    n = 0;
    do begin tick(0); n++; end while (pll_reset_o && n < 50);
    chk("bringup pll_reset_fall", n, RC);
    tick(0); n++;
    do begin tick(1); n++; end while (!sys_rst_n_o && n < 100);
    chk("bringup sys_release_cycle", n, RC + 2 + 2 + SC);
    chk("bringup retry", retry_cnt_o, 0);
`ifdef PLL_LOCK_DEGLITCH_EN
    repeat (2) tick(0);
    repeat (4) tick(1);
    chk("deglitch short sys_rst_n", sys_rst_n_o, 1);
    chk("deglitch short loss", loss_cnt_o, 0);
    repeat (3) tick(0);
    repeat (2) tick(1);
    chk("deglitch long state", state_o, 0);
    chk("deglitch long loss", loss_cnt_o, 1);
`endif
    // Timeout rounds into fault
    do_reset();
    repeat (24) tick(0);
    chk("timeout1 retry", retry_cnt_o, 1);
    chk("timeout1 state", state_o, 0);
    repeat (24) tick(0);
    chk("timeout2 retry", retry_cnt_o, 2);
    repeat (24) tick(0);
    chk("timeout3 retry", retry_cnt_o, 3);
    chk("timeout3 fault", fault_o, 1);
    chk("timeout3 pll_reset", pll_reset_o, 1);
    for (int k = 0; k < 20; k++) tick(k[0]);
    chk("fault sticky", fault_o, 1);
    chk("fault state", state_o, 4);
    chk("fault pll_reset held", pll_reset_o, 1);
    // Lock drop during STABLE
    do_reset();
    repeat (6) tick(0);
    repeat (6) tick(1);
    chk("stable reached", state_o, 2);
    repeat (3) tick(0);
    chk("stable drop state", state_o, 1);
    chk("stable drop retry", retry_cnt_o, 0);
    repeat (13) tick(1);
    chk("stable relock run", state_o, 3);
    // Five losses, then async reset between edges
    for (int r = 0; r < 5; r++) begin
      repeat (GC) tick(0);
      n = 0;
      do begin tick(1); n++; end while (!ready_o && n < 100);
      chk("loss rerun ready", ready_o, 1);
    end
    chk("loss count 5", loss_cnt_o, 5);
    #2 rst_n = 1'b0;
    #1;
    chk("async state", state_o, 0);
    chk("async pll_reset", pll_reset_o, 1);
    chk("async sys_rst_n", sys_rst_n_o, 0);
    chk("async ready", ready_o, 0);
    chk("async retry", retry_cnt_o, 0);
    chk("async loss", loss_cnt_o, 0);
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    // Randomized lock bursts
    n = 0;
    while (n < 4000) begin
      bit lk;
      int len;
      lk  = 1'($urandom_range(0, 1));
      len = lk ? $urandom_range(1, 40) : $urandom_range(1, 25);
      for (int k = 0; k < len; k++) tick(lk);
      n += len;
      if (m_st == 4 && $urandom_range(0, 2) == 0) do_reset();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
